// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select of a shared 4:1 mux.
// The owner keeps the grant until it drops its request, or until HOLD_MAX
// grant cycles have passed while another requester is waiting.
// At least one idle cycle with grant=0 separates any two owners
// (break-before-make).
// Optional feature: define MUX4_ARB_LOCK_EN to add a 'lock' input. While lock
// is high in GRANT, timeout preemption is held off.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Last hold_cnt value before a timeout can fire.
  // With HOLD_MAX=0, preemption is disabled.
  localparam bit         HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(HOLD_MAX - 1) : 8'd0;

  state_t     r_state;
  logic [3:0] r_grant;
  logic [1:0] r_sel;
  logic [1:0] r_last;
  logic [7:0] r_hold_cnt;
  logic       r_busy;
  logic       r_preempt;

  state_t     w_state_nxt;
  logic [3:0] w_grant_nxt;
  logic [1:0] w_sel_nxt;
  logic [1:0] w_last_nxt;
  logic [7:0] w_hold_nxt;
  logic       w_busy_nxt;
  logic       w_preempt_nxt;
  logic [1:0] w_winner;
  logic       w_others;
  logic       w_lock;
  logic       w_timeout;

  // Search order is last+1 .. last+4 (mod 4).
  // The previous owner is checked last, so it wins only when it is the sole requester.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    rr_pick = l;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    onehot4 = 4'b0001 << i;
  endfunction

`ifdef MUX4_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_winner  = rr_pick(req, r_last);
  assign w_others  = |(req & ~r_grant);
  assign w_timeout = HOLD_EN && (r_hold_cnt == HOLD_LAST) && w_others && !w_lock;

  // Next-state and next-output logic for the IDLE/GRANT arbiter.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_last_nxt    = r_last;
    w_hold_nxt    = r_hold_cnt;
    w_busy_nxt    = r_busy;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = onehot4(w_winner);
          w_sel_nxt   = w_winner;
          w_last_nxt  = w_winner;
          w_hold_nxt  = 8'd0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_GRANT: begin
        // A request drop counts as a release and takes priority over a timeout.
        if (!req[r_sel]) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
        end else if (w_timeout) begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_preempt_nxt = 1'b1;
        end else begin
          if (r_hold_cnt != HOLD_LAST) begin
            w_hold_nxt = r_hold_cnt + 8'd1;
          end else begin
            w_hold_nxt = r_hold_cnt;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered-output update, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= 4'b0000;
      r_sel      <= 2'd0;
      r_last     <= 2'd3;
      r_hold_cnt <= 8'd0;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_busy     <= w_busy_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with HOLD_MAX=8.
// Inputs change 1 time unit after a rising edge.
// Outputs are also checked at that point.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock;
`endif

  int total;
  int bad;

  mux4_rr_arbiter #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
`ifdef MUX4_ARB_LOCK_EN
    .lock    (lock),
`endif
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input logic ep);
    total++;
    assert (grant === eg) else begin
      bad++;
      $error("FAIL %s.grant observed=%b expected=%b", tag, grant, eg);
    end
    total++;
    assert (sel === es) else begin
      bad++;
      $error("FAIL %s.sel observed=%0d expected=%0d", tag, sel, es);
    end
    total++;
    assert (busy === eb) else begin
      bad++;
      $error("FAIL %s.busy observed=%b expected=%b", tag, busy, eb);
    end
    total++;
    assert (preempt === ep) else begin
      bad++;
      $error("FAIL %s.preempt observed=%b expected=%b", tag, preempt, ep);
    end
  endtask

  initial begin
    int         order [5];
    logic [3:0] oh;
    total = 0;
    bad   = 0;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = 4'b0000;
`ifdef MUX4_ARB_LOCK_EN
    lock  = 1'b0;
`endif

    // Reset state
    #2;
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request: grant one clock later, then asynchronous reset mid-grant
    req = 4'b0001;
    tick();
    chk("single_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk("single_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();

    // Rotation with all four requesting; each owner holds 3 cycles
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << order[i];
      chk("rr_grant", oh, 2'(order[i]), 1'b1, 1'b0);
      tick();
      chk("rr_hold1", oh, 2'(order[i]), 1'b1, 1'b0);
      tick();
      chk("rr_hold2", oh, 2'(order[i]), 1'b1, 1'b0);
      req = req & ~oh;
      tick();
      chk("rr_gap", 4'b0000, 2'(order[i]), 1'b0, 1'b0);
      if (i < 4) begin
        req = req | oh;
      end else begin
        req = 4'b0000;
      end
      tick();
    end
    chk("rr_idle_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Timeout preemption: owner 0, requester 2 arrives two cycles after grant
    req = 4'b0001;
    tick();
    chk("pre_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int j = 1; j <= 7; j++) begin
      if (j == 3) req = 4'b0101;
      tick();
      chk("pre_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk("pre_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk("pre_next", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    chk("pre_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    chk("pre_regrant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    tick();

    // Lone owner keeps the grant indefinitely
    req = 4'b0010;
    tick();
    for (int j = 0; j < 50; j++) begin
      chk("lone", 4'b0010, 2'd1, 1'b1, 1'b0);
      tick();
    end
    req = 4'b0000;
    tick();
    chk("lone_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();

    // Release coinciding with the timeout: counts as a release, no preempt
    req = 4'b0100;
    tick();
    chk("rt_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0101;
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk("rt_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0001;
    tick();
    chk("rt_release", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    chk("rt_next", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    tick();

`ifdef MUX4_ARB_LOCK_EN
    // Lock holds off preemption until it drops
    req = 4'b0001;
    tick();
    chk("lk_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req  = 4'b1001;
    lock = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("lk_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    lock = 1'b0;
    tick();
    chk("lk_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk("lk_next", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
